// File: rtl/band_mixer.sv
// Three-band gain/mix stage: {hp,bp,lp} beats in, one rounded and saturated sample out.
// Optional saturating clip counter built only when BAND_MIXER_CLIP_CNT_EN is defined.
module band_mixer #(
  parameter int DATA_WIDTH = 16,
  parameter int GAIN_WIDTH = 16,
  parameter int GAIN_FRAC  = 12
) (
  input  logic                         pi_clk,
  input  logic                         pi_arst_n,
  input  logic [3*DATA_WIDTH-1:0]      pi_data_tdata,
  input  logic                         pi_data_tvalid,
  output logic                         pi_data_tready,
  input  logic                         pi_data_tlast,
  output logic [DATA_WIDTH-1:0]        po_data_tdata,
  output logic                         po_data_tvalid,
  input  logic                         po_data_tready,
  output logic                         po_data_tlast,
  input  logic signed [GAIN_WIDTH-1:0] pi_gain_hp,
  input  logic signed [GAIN_WIDTH-1:0] pi_gain_bp,
  input  logic signed [GAIN_WIDTH-1:0] pi_gain_lp,
  input  logic                         pi_gain_load,
  output logic                         po_gain_pending,
  output logic                         po_clip,
  input  logic                         pi_clip_cnt_clr,
  output logic [15:0]                  po_clip_cnt
);

  localparam int DW = DATA_WIDTH;
  localparam int GW = GAIN_WIDTH;
  localparam int PW = DW + GW;
  localparam int AW = PW + 2;
  localparam logic signed [GW-1:0] UNITY   = GW'(2 ** GAIN_FRAC);
  localparam logic signed [AW-1:0] RND     = AW'(2 ** (GAIN_FRAC - 1));
  localparam logic signed [AW-1:0] SAT_MAX = AW'(2 ** (DW - 1) - 1);
  localparam logic signed [AW-1:0] SAT_MIN = ~SAT_MAX;

  typedef enum logic {G_IDLE, G_PEND} gain_state_e;

  // Handshake: a beat moves on a cycle where valid and ready are both high;
  // the whole pipeline advances together whenever the output slot can drain.
  logic en, accept, apply;
  assign en             = !po_data_tvalid || po_data_tready;
  assign pi_data_tready = en;
  assign accept         = pi_data_tvalid && en;

  gain_state_e state_q;
  logic frame_start_q;
  logic signed [GW-1:0] sh_hp_q, sh_bp_q, sh_lp_q;
  logic signed [GW-1:0] act_hp_q, act_bp_q, act_lp_q;
  logic signed [GW-1:0] eff_hp, eff_bp, eff_lp;

  // A fresh load on a frame-start accept wins over an older shadow value.
  assign apply = accept && frame_start_q && (pi_gain_load || state_q == G_PEND);

  always_comb begin
    eff_hp = act_hp_q;
    eff_bp = act_bp_q;
    eff_lp = act_lp_q;
    if (apply) begin
      eff_hp = pi_gain_load ? pi_gain_hp : sh_hp_q;
      eff_bp = pi_gain_load ? pi_gain_bp : sh_bp_q;
      eff_lp = pi_gain_load ? pi_gain_lp : sh_lp_q;
    end
  end

  always_ff @(posedge pi_clk or negedge pi_arst_n) begin
    if (!pi_arst_n) begin
      state_q       <= G_IDLE;
      frame_start_q <= 1'b1;
      sh_hp_q       <= UNITY;
      sh_bp_q       <= UNITY;
      sh_lp_q       <= UNITY;
      act_hp_q      <= UNITY;
      act_bp_q      <= UNITY;
      act_lp_q      <= UNITY;
    end else begin
      if (pi_gain_load) begin
        sh_hp_q <= pi_gain_hp;
        sh_bp_q <= pi_gain_bp;
        sh_lp_q <= pi_gain_lp;
      end
      if (apply) begin
        act_hp_q <= eff_hp;
        act_bp_q <= eff_bp;
        act_lp_q <= eff_lp;
        state_q  <= G_IDLE;
      end else if (pi_gain_load) begin
        state_q <= G_PEND;
      end
      if (accept) frame_start_q <= pi_data_tlast;
    end
  end

  assign po_gain_pending = (state_q == G_PEND);

  logic v1_q, v2_q, last1_q, last2_q, clip_q;
  logic signed [DW-1:0] b_hp_q, b_bp_q, b_lp_q;
  logic signed [GW-1:0] g_hp_q, g_bp_q, g_lp_q;
  logic signed [PW-1:0] p_hp_q, p_bp_q, p_lp_q;
  logic signed [AW-1:0] acc, shr;
  logic [DW-1:0] sample_d;
  logic sat_d;

  always_comb begin
    acc      = AW'(p_hp_q) + AW'(p_bp_q) + AW'(p_lp_q) + RND;
    shr      = acc >>> GAIN_FRAC;
    sample_d = shr[DW-1:0];
    sat_d    = 1'b0;
    if (shr > SAT_MAX) begin
      sample_d = SAT_MAX[DW-1:0];
      sat_d    = 1'b1;
    end else if (shr < SAT_MIN) begin
      sample_d = SAT_MIN[DW-1:0];
      sat_d    = 1'b1;
    end
  end

  always_ff @(posedge pi_clk or negedge pi_arst_n) begin
    if (!pi_arst_n) begin
      v1_q <= 1'b0; v2_q <= 1'b0; po_data_tvalid <= 1'b0;
      last1_q <= 1'b0; last2_q <= 1'b0; po_data_tlast <= 1'b0;
      b_hp_q <= '0; b_bp_q <= '0; b_lp_q <= '0;
      g_hp_q <= '0; g_bp_q <= '0; g_lp_q <= '0;
      p_hp_q <= '0; p_bp_q <= '0; p_lp_q <= '0;
      po_data_tdata <= '0;
      clip_q        <= 1'b0;
    end else if (en) begin
      v1_q    <= pi_data_tvalid;
      last1_q <= pi_data_tvalid && pi_data_tlast;
      b_hp_q  <= $signed(pi_data_tdata[3*DW-1:2*DW]);
      b_bp_q  <= $signed(pi_data_tdata[2*DW-1:DW]);
      b_lp_q  <= $signed(pi_data_tdata[DW-1:0]);
      g_hp_q  <= eff_hp;
      g_bp_q  <= eff_bp;
      g_lp_q  <= eff_lp;
      v2_q    <= v1_q;
      last2_q <= last1_q;
      p_hp_q  <= PW'(b_hp_q) * PW'(g_hp_q);
      p_bp_q  <= PW'(b_bp_q) * PW'(g_bp_q);
      p_lp_q  <= PW'(b_lp_q) * PW'(g_lp_q);
      po_data_tvalid <= v2_q;
      po_data_tlast  <= last2_q;
      po_data_tdata  <= sample_d;
      clip_q         <= v2_q && sat_d;
    end
  end

  assign po_clip = clip_q;

`ifdef BAND_MIXER_CLIP_CNT_EN
  logic [15:0] clip_cnt_q;
  always_ff @(posedge pi_clk or negedge pi_arst_n) begin
    if (!pi_arst_n) begin
      clip_cnt_q <= '0;
    end else if (pi_clip_cnt_clr) begin
      clip_cnt_q <= '0;
    end else if (po_data_tvalid && po_data_tready && clip_q && clip_cnt_q != 16'hFFFF) begin
      clip_cnt_q <= clip_cnt_q + 16'd1;
    end
  end
  assign po_clip_cnt = clip_cnt_q;
`else
  logic unused_clip_cnt_clr;
  assign unused_clip_cnt_clr = pi_clip_cnt_clr;
  assign po_clip_cnt         = '0;
`endif

endmodule

// File: tb/tb_band_mixer.sv
// Bench for band_mixer: random/directed beats checked against an arithmetic mix model.
module tb_band_mixer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [47:0] pi_data_tdata = '0;
  logic        pi_data_tvalid = 1'b0;
  logic        pi_data_tready;
  logic        pi_data_tlast = 1'b0;
  logic [15:0] po_data_tdata;
  logic        po_data_tvalid;
  logic        po_data_tready = 1'b1;
  logic        po_data_tlast;
  logic [15:0] pi_gain_hp = 16'h1000;
  logic [15:0] pi_gain_bp = 16'h1000;
  logic [15:0] pi_gain_lp = 16'h1000;
  logic        pi_gain_load = 1'b0;
  logic        po_gain_pending;
  logic        po_clip;
  logic        pi_clip_cnt_clr = 1'b0;
  logic [15:0] po_clip_cnt;

  always #5 clk = ~clk;

  band_mixer dut (
    .pi_clk(clk), .pi_arst_n(rst_n),
    .pi_data_tdata(pi_data_tdata), .pi_data_tvalid(pi_data_tvalid),
    .pi_data_tready(pi_data_tready), .pi_data_tlast(pi_data_tlast),
    .po_data_tdata(po_data_tdata), .po_data_tvalid(po_data_tvalid),
    .po_data_tready(po_data_tready), .po_data_tlast(po_data_tlast),
    .pi_gain_hp(pi_gain_hp), .pi_gain_bp(pi_gain_bp), .pi_gain_lp(pi_gain_lp),
    .pi_gain_load(pi_gain_load), .po_gain_pending(po_gain_pending),
    .po_clip(po_clip), .pi_clip_cnt_clr(pi_clip_cnt_clr), .po_clip_cnt(po_clip_cnt)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state; gains indexed like the tdata slices: 0=lp, 1=bp, 2=hp.
  int          act_g[3];
  int          sh_g[3];
  bit          pend_m;
  bit          fs_m;
  int          cnt_m;
  logic [17:0] exp_q[$];
  logic [15:0] last_out;
  int          out_cnt = 0;
  int          bp_mode = 0;

  function automatic logic [17:0] model_mix(input logic [47:0] td, input logic last, input int g[3]);
    longint acc;
    longint r;
    logic [15:0] band;
    logic clip;
    acc = 2048;
    for (int i = 0; i < 3; i++) begin
      band = td[i*16 +: 16];
      acc  = acc + longint'($signed(band)) * longint'(g[i]);
    end
    r    = acc >>> 12;
    clip = 1'b0;
    if (r > 32767) begin r = 32767; clip = 1'b1; end
    if (r < -32768) begin r = -32768; clip = 1'b1; end
    return {last, clip, 16'(r)};
  endfunction

  task automatic model_monitor();
    logic [17:0] e;
    logic [17:0] prev_out = '0;
    bit hold_chk = 1'b0;
    forever begin
      @(negedge clk or negedge rst_n);
      if (!rst_n) begin
        act_g = '{4096, 4096, 4096};
        sh_g  = '{4096, 4096, 4096};
        pend_m = 1'b0; fs_m = 1'b1; cnt_m = 0; hold_chk = 1'b0;
        exp_q.delete();
      end else begin
        if (hold_chk) begin
          checks++;
          if (po_data_tvalid !== 1'b1 || {po_data_tlast, po_clip, po_data_tdata} !== prev_out) begin
            errors++;
            $display("FAIL hold: got v=%0b %h required v=1 %h", po_data_tvalid,
                     {po_data_tlast, po_clip, po_data_tdata}, prev_out);
          end
        end
        if (pi_clip_cnt_clr) cnt_m = 0;
        if (po_data_tvalid && po_data_tready) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL out_unexpected: got %h with empty expected queue", po_data_tdata);
          end else begin
            e = exp_q.pop_front();
            if ({po_data_tlast, po_clip, po_data_tdata} !== e) begin
              errors++;
              $display("FAIL out_beat: got last/clip/data %h required %h",
                       {po_data_tlast, po_clip, po_data_tdata}, e);
            end
`ifdef BAND_MIXER_CLIP_CNT_EN
            if (e[16] && !pi_clip_cnt_clr && cnt_m < 65535) cnt_m++;
`endif
          end
          last_out = po_data_tdata;
          out_cnt++;
        end
        hold_chk = po_data_tvalid && !po_data_tready;
        prev_out = {po_data_tlast, po_clip, po_data_tdata};
        if (pi_gain_load) begin
          sh_g[2] = $signed(pi_gain_hp);
          sh_g[1] = $signed(pi_gain_bp);
          sh_g[0] = $signed(pi_gain_lp);
          pend_m  = 1'b1;
        end
        if (pi_data_tvalid && pi_data_tready) begin
          if (fs_m && pend_m) begin
            act_g  = sh_g;
            pend_m = 1'b0;
          end
          exp_q.push_back(model_mix(pi_data_tdata, pi_data_tlast, act_g));
          fs_m = pi_data_tlast;
        end
      end
    end
  endtask

  task automatic bp_driver();
    int ph = 0;
    forever begin
      @(posedge clk);
      #1;
      case (bp_mode)
        1: begin po_data_tready = (ph == 0); ph = (ph + 1) % 3; end
        2: po_data_tready = 1'($urandom_range(0, 1));
        default: po_data_tready = 1'b1;
      endcase
    end
  endtask

  // Drivers start and end at posedge+#1.
  task automatic send_beat(input int hp, input int bp, input int lp, input bit last, input bit ld);
    bit acc = 1'b0;
    int n = 0;
    pi_data_tdata  = {16'(hp), 16'(bp), 16'(lp)};
    pi_data_tlast  = last;
    pi_data_tvalid = 1'b1;
    pi_gain_load   = ld;
    while (!acc && n < 200) begin
      @(negedge clk);
      acc = pi_data_tready;
      @(posedge clk);
      #1;
      pi_gain_load = 1'b0;
      n++;
    end
    if (!acc) begin
      checks++; errors++;
      $display("FAIL accept_timeout: tready=%0b required 1 within 200 cycles", pi_data_tready);
    end
    pi_data_tvalid = 1'b0;
    pi_data_tlast  = 1'b0;
  endtask

  task automatic pulse_load(input int ghp, input int gbp, input int glp);
    pi_gain_hp = 16'(ghp); pi_gain_bp = 16'(gbp); pi_gain_lp = 16'(glp);
    pi_gain_load = 1'b1;
    @(posedge clk);
    #1;
    pi_gain_load = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 1000) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d beats outstanding required 0", exp_q.size());
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    checks++;
    if ({po_data_tvalid, po_data_tlast, po_clip, po_gain_pending} !== 4'b0000 ||
        po_data_tdata !== 16'd0 || po_clip_cnt !== 16'd0) begin
      errors++;
      $display("FAIL reset_state: v/last/clip/pend=%b data=%h cnt=%h required 0000/0000/0000",
               {po_data_tvalid, po_data_tlast, po_clip, po_gain_pending}, po_data_tdata, po_clip_cnt);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    send_beat(100, 200, 300, 1'b1, 1'b0);
    repeat (2) @(negedge clk);
    checks++;
    if (po_data_tvalid !== 1'b0) begin
      errors++; $display("FAIL latency_early: tvalid=%0b required 0", po_data_tvalid);
    end
    @(negedge clk);
    checks++;
    if (po_data_tvalid !== 1'b1 || po_data_tdata !== 16'd600 || po_clip !== 1'b0) begin
      errors++;
      $display("FAIL latency_3: v=%0b data=%0d clip=%0b required 1 600 0",
               po_data_tvalid, $signed(po_data_tdata), po_clip);
    end
    @(posedge clk);
    #1;
    wait_drain();
  endtask

  task automatic test_saturation();
    send_beat(20000, 20000, 20000, 1'b1, 1'b0);
    send_beat(-20000, -20000, -20000, 1'b1, 1'b0);
    wait_drain();
    checks++;
    if (last_out !== 16'h8000) begin
      errors++; $display("FAIL sat_neg: got %h required 8000", last_out);
    end
    checks++;
`ifdef BAND_MIXER_CLIP_CNT_EN
    if (po_clip_cnt !== 16'd2) begin
      errors++; $display("FAIL clip_cnt: got %0d required 2", po_clip_cnt);
    end
`else
    if (po_clip_cnt !== 16'd0) begin
      errors++; $display("FAIL clip_cnt: got %0d required 0", po_clip_cnt);
    end
`endif
    pi_clip_cnt_clr = 1'b1;
    @(posedge clk);
    #1;
    pi_clip_cnt_clr = 1'b0;
    checks++;
    if (po_clip_cnt !== 16'd0) begin
      errors++; $display("FAIL clip_cnt_clr: got %0d required 0", po_clip_cnt);
    end
  endtask

  task automatic test_rounding();
    int hp_v[3]  = '{3, -3, 1};
    int exp_v[3] = '{2, -1, 1};
    pulse_load(16'h0800, 0, 0);
    checks++;
    if (po_gain_pending !== 1'b1) begin
      errors++; $display("FAIL round_pending: got %0b required 1", po_gain_pending);
    end
    for (int i = 0; i < 3; i++) begin
      send_beat(hp_v[i], 0, 0, 1'b1, 1'b0);
      wait_drain();
      checks++;
      if ($signed(last_out) !== exp_v[i]) begin
        errors++;
        $display("FAIL round_%0d: got %0d required %0d", hp_v[i], $signed(last_out), exp_v[i]);
      end
    end
  endtask

  task automatic test_gain_mid_frame();
    pulse_load(4096, 4096, 4096);
    for (int i = 1; i <= 3; i++) send_beat(0, 0, 100, 1'b0, 1'b0);
    pulse_load(4096, 4096, 16'h2000);
    for (int i = 4; i <= 8; i++) send_beat(0, 0, 100, i == 8, 1'b0);
    wait_drain();
    checks++;
    if (last_out !== 16'd100 || po_gain_pending !== 1'b1) begin
      errors++;
      $display("FAIL midframe_hold: got %0d pend=%0b required 100 pend=1", last_out, po_gain_pending);
    end
    send_beat(0, 0, 100, 1'b1, 1'b0);
    checks++;
    if (po_gain_pending !== 1'b0) begin
      errors++; $display("FAIL midframe_pend_fall: got %0b required 0", po_gain_pending);
    end
    wait_drain();
    checks++;
    if (last_out !== 16'd200) begin
      errors++; $display("FAIL midframe_apply: got %0d required 200", last_out);
    end
    pi_gain_hp = 16'h1000; pi_gain_bp = 16'h1000; pi_gain_lp = 16'h1000;
    send_beat(0, 0, 100, 1'b1, 1'b1);
    wait_drain();
    checks++;
    if (last_out !== 16'd100 || po_gain_pending !== 1'b0) begin
      errors++;
      $display("FAIL load_at_frame_start: got %0d pend=%0b required 100 pend=0", last_out, po_gain_pending);
    end
  endtask

  task automatic test_backpressure();
    int c0 = out_cnt;
    bp_mode = 1;
    for (int i = 0; i < 10; i++)
      send_beat($urandom_range(0, 8000) - 4000, $urandom_range(0, 8000) - 4000,
                $urandom_range(0, 8000) - 4000, (i % 5) == 4, 1'b0);
    wait_drain();
    bp_mode = 0;
    checks++;
    if (out_cnt - c0 !== 10) begin
      errors++; $display("FAIL bp_count: got %0d required 10", out_cnt - c0);
    end
  endtask

  task automatic test_random();
    bp_mode = 2;
    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 7) == 0)
        pulse_load($urandom_range(0, 32767) - 16384, $urandom_range(0, 32767) - 16384,
                   $urandom_range(0, 32767) - 16384);
      pi_gain_hp = 16'($urandom_range(0, 16383) - 8192);
      pi_gain_bp = 16'($urandom_range(0, 16383) - 8192);
      pi_gain_lp = 16'($urandom_range(0, 16383) - 8192);
      send_beat($urandom_range(0, 65535) - 32768, $urandom_range(0, 65535) - 32768,
                $urandom_range(0, 65535) - 32768, $urandom_range(0, 5) == 0,
                $urandom_range(0, 9) == 0);
    end
    send_beat(1, 2, 3, 1'b1, 1'b0);
    wait_drain();
    bp_mode = 0;
  endtask

  task automatic test_reset_mid();
    int c0;
    pulse_load(16'h2000, 16'h2000, 16'h2000);
    send_beat(1, 1, 1, 1'b1, 1'b0);
    wait_drain();
    for (int i = 0; i < 3; i++) send_beat(7, 7, 7, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    checks++;
    if (po_data_tvalid !== 1'b0 || po_data_tdata !== 16'd0) begin
      errors++;
      $display("FAIL async_reset: v=%0b data=%h required 0 0000", po_data_tvalid, po_data_tdata);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (po_gain_pending !== 1'b0 || po_clip_cnt !== 16'd0) begin
      errors++;
      $display("FAIL post_reset_state: pend=%0b cnt=%0d required 0 0", po_gain_pending, po_clip_cnt);
    end
    c0 = out_cnt;
    send_beat(100, 200, 300, 1'b1, 1'b0);
    wait_drain();
    checks++;
    if (last_out !== 16'd600 || out_cnt - c0 !== 1) begin
      errors++;
      $display("FAIL post_reset_beat: got %0d (%0d beats) required 600 (1 beat)", last_out, out_cnt - c0);
    end
  endtask

  initial begin
    fork
      model_monitor();
      bp_driver();
    join_none
    test_reset();
    test_basic();
    test_saturation();
    test_rounding();
    test_gain_mid_frame();
    test_backpressure();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
